// File: rtl/instr_fetch.sv
// instr_fetch: fetch sequencer between the program counter and instruction memory.
// Issues one read per instruction, holds the returned word for the decoder,
// pulses next_ins once the decoder accepts it, and counts retirements.
// Optional feature: define FETCH_TIMEOUT_EN to enable the WAIT watchdog that
// raises fetch_err and halts after TIMEOUT cycles without read data.
module instr_fetch #(
  parameter int PC_BITS    = 12,
  parameter int INSTR_BITS = 9,
  parameter int TIMEOUT    = 15,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_BITS-1:0]    pc,
  input  logic                  done,
  output logic                  mem_req,
  output logic [PC_BITS-1:0]    mem_addr,
  input  logic [INSTR_BITS-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic [INSTR_BITS-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  next_ins,
  output logic                  halted,
  output logic                  fetch_err,
  output logic [CNT_BITS-1:0]   retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] REQ    = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] SETTLE = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] wait_cnt;

  // Watchdog fires on the TIMEOUT-th consecutive WAIT cycle without data.
  always_comb begin
    timeout_hit = 1'b0;
    if (state == WAIT && !mem_rvalid && wait_cnt == TW'(TIMEOUT - 1)) begin
      timeout_hit = 1'b1;
    end
  end

  // Count WAIT cycles without read data; held at zero outside WAIT so every
  // entry into WAIT starts from a cleared count.
  always_ff @(posedge clock) begin
    if (reset || state != WAIT) begin
      wait_cnt <= '0;
    end else if (!mem_rvalid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky fetch error, cleared only by reset or a new program start.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (start) begin
      fetch_err <= 1'b0;
    end else if (timeout_hit) begin
      fetch_err <= 1'b1;
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic timeout_unused;
  assign timeout_unused = TIMEOUT[0];
  assign timeout_hit    = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // Next-state selection; start overrides every state, reset is applied in
  // the state register.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ARM;
    end else begin
      case (state)
        IDLE:   state_next = IDLE;
        ARM:    state_next = REQ;
        REQ:    state_next = done ? HALT : WAIT;
        WAIT: begin
          if (mem_rvalid) begin
            state_next = HOLD;
          end else if (timeout_hit) begin
            state_next = HALT;
          end
        end
        HOLD:   if (instr_ready) state_next = SETTLE;
        SETTLE: state_next = REQ;
        HALT:   state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The read strobe is combinational in REQ so memory sees the live PC; start
  // and reset suppress it because both abandon the fetch this cycle.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    if (state == REQ && !done && !start && !reset) begin
      mem_req  = 1'b1;
      mem_addr = pc;
    end
  end

  // Instruction capture, decoder handshake, halt flag and retirement count.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      next_ins    <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      next_ins <= 1'b0;
      if (start) begin
        instr_valid <= 1'b0;
        halted      <= 1'b0;
        retired     <= '0;
      end else begin
        case (state)
          REQ: begin
            if (done) begin
              halted <= 1'b1;
            end
          end
          WAIT: begin
            if (mem_rvalid) begin
              instr       <= mem_rdata;
              instr_valid <= 1'b1;
            end else if (timeout_hit) begin
              halted <= 1'b1;
            end
          end
          HOLD: begin
            if (instr_ready) begin
              next_ins    <= 1'b1;
              instr_valid <= 1'b0;
              retired     <= retired + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // next_ins is a single-cycle pulse: SETTLE always follows the accepting HOLD.
  a_next_ins_single: assert property (@(posedge clock) next_ins |=> !next_ins);

  // A held instruction stays valid and unchanged until the decoder takes it.
  a_hold_stable: assert property (@(posedge clock)
    (instr_valid && !instr_ready && !reset && !start) |=> (instr_valid && $stable(instr)));

endmodule
